s2m_stream_writer: RTL and testbench
====================================

S2M_STREAM_WRITER -- requirements
Module: s2m_stream_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, giving the sample and write-data width; it must match the s2m buffer write slave.
REQ-002 SHALL have parameter FRAME_LEN, default 16, giving the data words per frame; legal range is 2..4096.
REQ-003 SHALL have port clock, input, 1 bit: single clock, the same clock as the s2m buffer write side.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1 bit: permits acceptance of new samples.
REQ-006 SHALL have port snk_data, input, DATA_W bits: Avalon-ST sample.
REQ-007 SHALL have port snk_valid, input, 1 bit: sample valid.
REQ-008 SHALL have port snk_ready, output, 1 bit: writer can take a sample.
REQ-009 SHALL have port avm_write, output, 1 bit: Avalon-MM write request to the s2m buffer write slave.
REQ-010 SHALL have port avm_writedata, output, DATA_W bits: write data.
REQ-011 SHALL have port avm_waitrequest, input, 1 bit: buffer full or buffer in reset.
REQ-012 SHALL have port frame_count, output, 16 bits: completed frames.
REQ-013 SHALL have port busy, output, 1 bit: word held or frame in progress.

Function
REQ-014 SHALL hold at most one word in a hold register; hold_valid drives avm_write and the hold register drives avm_writedata.
REQ-015 SHALL count a write as accepted in the cycle where avm_write=1 and avm_waitrequest=0.
REQ-016 SHALL keep avm_write and avm_writedata stable while avm_waitrequest=1, and SHALL never withdraw a write before it is accepted.
REQ-017 SHALL drive snk_ready = enable & (state==DATA) & (~hold_valid | write accepted this cycle), combinationally from avm_waitrequest.
REQ-018 SHALL load a sample into the hold register when snk_valid & snk_ready, with avm_write asserted the next cycle (latency 1).
REQ-019 SHALL sustain 1 word/cycle while avm_waitrequest=0.
REQ-020 SHALL use the FSM IDLE -> DATA when enable=1 (HDR also exists when configured, see REQ-031).
REQ-021 SHALL transition DATA -> IDLE when enable=0 and hold_valid=0.
REQ-022 SHALL keep a word counter, 0..FRAME_LEN-1, that increments on each data-word acceptance and wraps to 0 after FRAME_LEN-1.
REQ-023 SHALL increment frame_count on acceptance of the last data word of a frame, wrapping 0xFFFF -> 0x0000.
REQ-024 SHALL, when enable deasserts, stop taking new samples; a held word SHALL still be written (no data loss).
REQ-025 SHALL NOT reset the word counter when enable deasserts; a resumed frame continues at the same position.
REQ-026 SHALL drive busy = hold_valid | (word counter != 0).
REQ-027 SHALL, when a sample is offered and a write is accepted in the same cycle, drain and reload the hold register in that cycle.

Reset
REQ-028 SHALL, while reset_n=0 (asynchronous), force snk_ready=0, avm_write=0, avm_writedata=0, frame_count=0, busy=0, FSM=IDLE and word counter=0.
REQ-029 SHALL discard any held, unaccepted word on reset mid-operation.
REQ-030 SHALL leave FSM=IDLE on the first clock edge after release, and no sooner.

Configuration
REQ-031 SHALL, with S2M_WRITER_SEQ_HEADER_EN defined, add FSM state HDR, entered from IDLE or DATA whenever the word counter is 0, enable=1 and the hold register is free.
REQ-032 SHALL, in HDR, load the header {4'hA, frame_count[11:0]} zero-extended to DATA_W, hold snk_ready=0, not advance the word counter, and go to DATA next cycle.
REQ-033 SHALL, without S2M_WRITER_SEQ_HEADER_EN, have no HDR state and produce a stream that is data words only.

Structure
REQ-034 SHALL place in the shared package s2m_pkg: the default DATA_W, the FSM state enum, and the header tag constant 4'hA.
REQ-035 SHALL implement the hold register and its accept/drain logic as one sub-module, s2m_hold_reg.

Verification
REQ-036 SHALL cover streaming: 32 samples 0x0001..0x0020, waitrequest=0 -> 32 writes in 32 consecutive cycles, in order, frame_count=2.
REQ-037 SHALL cover backpressure: waitrequest=1 for 5 cycles mid-stream -> avm_writedata frozen, snk_ready=0, no loss or duplicate.
REQ-038 SHALL cover pause: enable low after sample 7 of a frame -> held word written, busy stays 1, and resume continues at word 7.
REQ-039 SHALL cover reset: reset_n pulsed while a word is held -> all outputs 0 immediately and the word is never written.
REQ-040 SHALL cover the header: with S2M_WRITER_SEQ_HEADER_EN and FRAME_LEN=4, 8 samples -> 0xA000, d0..d3, 0xA001, d4..d7.
REQ-041 SHALL cover wrap: frame_count preloaded to 0xFFFF via a forced run -> next frame completes and frame_count=0x0000.

Source files
------------

// File: rtl/s2m_pkg.sv
// Shared definitions for the s2m stream writer: default width, FSM states and
// the sequence-header tag/format.
package s2m_pkg;

  localparam int S2M_DATA_W = 16;

  localparam logic [3:0] S2M_HDR_TAG = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_HDR  = 2'd2
  } s2m_state_e;

  // Header word: tag in the top nibble, low 12 bits of the frame number.
  function automatic logic [15:0] s2m_header(input logic [15:0] frame_count);
    return {S2M_HDR_TAG, frame_count[11:0]};
  endfunction

endpackage

// File: rtl/s2m_hold_reg.sv
// Single-entry hold register feeding an Avalon-MM write master: loads one word,
// presents it until the slave accepts it, and allows drain+reload in one cycle.
module s2m_hold_reg
  import s2m_pkg::*;
#(
  parameter int DATA_W = S2M_DATA_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              waitrequest,
  output logic              hold_valid,
  output logic [DATA_W-1:0] hold_data,
  output logic              accept,
  output logic              free
);

  assign accept = hold_valid & ~waitrequest;
  assign free   = ~hold_valid | accept;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create ordering-dependent races.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid <= 1'b0;
      // NOTE: the data register is reset too, because it drives avm_writedata
      // directly and that bus must read zero while in reset.
      hold_data  <= '0;
    end else if (load) begin
      hold_valid <= 1'b1;
      hold_data  <= load_data;
    end else if (accept) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/s2m_stream_writer.sv
// Avalon-ST to Avalon-MM stream writer with frame counting. Define
// S2M_WRITER_SEQ_HEADER_EN to prefix every frame with a sequence header word.
module s2m_stream_writer
  import s2m_pkg::*;
#(
  parameter int DATA_W    = S2M_DATA_W,
  parameter int FRAME_LEN = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] snk_data,
  input  logic              snk_valid,
  output logic              snk_ready,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  output logic [15:0]       frame_count,
  output logic              busy
);

  localparam int               CNT_W     = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_LEN - 1);

  s2m_state_e        state_q, state_d;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [15:0]       frame_cnt_q;
  logic              hold_valid, accept, free, load;
  logic [DATA_W-1:0] load_data;
  logic              data_take, data_accept;

  s2m_hold_reg #(.DATA_W(DATA_W)) u_hold (
    .clock       (clock),
    .reset_n     (reset_n),
    .load        (load),
    .load_data   (load_data),
    .waitrequest (avm_waitrequest),
    .hold_valid  (hold_valid),
    .hold_data   (avm_writedata),
    .accept      (accept),
    .free        (free)
  );

`ifdef S2M_WRITER_SEQ_HEADER_EN
  // hdr_pending marks that the next word loaded must be a header; it is set
  // when the last data word of a frame is loaded, not when it is accepted, so
  // no data word of the next frame can slip in ahead of its header.
  logic             hdr_pending_q, held_hdr_q;
  logic [CNT_W-1:0] load_cnt_q;

  assign snk_ready   = enable & (state_q == ST_DATA) & free & ~hdr_pending_q;
  assign data_take   = snk_valid & snk_ready;
  assign load        = data_take | (state_q == ST_HDR);
  assign load_data   = (state_q == ST_HDR) ? DATA_W'(s2m_header(frame_cnt_q)) : snk_data;
  assign data_accept = accept & ~held_hdr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = (hdr_pending_q && free) ? ST_HDR : ST_DATA;
      ST_DATA: begin
        if (enable && hdr_pending_q && free) state_d = ST_HDR;
        else if (!enable && !hold_valid)     state_d = ST_IDLE;
      end
      ST_HDR:  state_d = ST_DATA;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hdr_pending_q <= 1'b1;
      held_hdr_q    <= 1'b0;
      load_cnt_q    <= '0;
    end else begin
      if (load) held_hdr_q <= (state_q == ST_HDR);
      if (data_take) begin
        load_cnt_q <= (load_cnt_q == LAST_WORD) ? '0 : load_cnt_q + CNT_W'(1);
        if (load_cnt_q == LAST_WORD) hdr_pending_q <= 1'b1;
      end else if (state_q == ST_HDR) begin
        hdr_pending_q <= 1'b0;
      end
    end
  end
`else
  assign snk_ready   = enable & (state_q == ST_DATA) & free;
  assign data_take   = snk_valid & snk_ready;
  assign load        = data_take;
  assign load_data   = snk_data;
  assign data_accept = accept;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_DATA;
      ST_DATA: if (!enable && !hold_valid) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
`endif

  // The word counter survives enable dropping so a paused frame resumes in place.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      word_cnt_q  <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (data_accept) begin
        if (word_cnt_q == LAST_WORD) begin
          word_cnt_q  <= '0;
          frame_cnt_q <= frame_cnt_q + 16'd1;
        end else begin
          word_cnt_q <= word_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign avm_write   = hold_valid;
  assign frame_count = frame_cnt_q;
  assign busy        = hold_valid | (word_cnt_q != '0);

endmodule

// File: tb/tb_s2m_stream_writer.sv
// Directed self-checking bench for s2m_stream_writer; the header scenario runs
// only when S2M_WRITER_SEQ_HEADER_EN is defined (with FRAME_LEN=4).
module tb_s2m_stream_writer;

`ifdef S2M_WRITER_SEQ_HEADER_EN
  localparam int FL = 4;
`else
  localparam int FL = 16;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] snk_data = '0;
  logic        snk_valid = 1'b0;
  logic        snk_ready;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [15:0] frame_count;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [15:0] wr_q[$];
  int          wr_cyc_q[$];
  logic        s_rdy, s_write;
  logic [15:0] s_wdata;

  s2m_stream_writer #(.DATA_W(16), .FRAME_LEN(FL)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .snk_data        (snk_data),
    .snk_valid       (snk_valid),
    .snk_ready       (snk_ready),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .frame_count     (frame_count),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  // One clock cycle: drive at the falling edge, observe 1 ns later, and log any
  // write that the next rising edge will accept.
  task automatic step(input logic en, input logic v, input logic [15:0] d,
                      input logic wr, output logic taken);
    @(negedge clock);
    enable = en; snk_valid = v; snk_data = d; avm_waitrequest = wr;
    #1;
    s_rdy = snk_ready; s_write = avm_write; s_wdata = avm_writedata;
    taken = v & snk_ready;
    if (avm_write && !avm_waitrequest) begin
      wr_q.push_back(avm_writedata);
      wr_cyc_q.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic test_reset;
    logic taken;
    reset_n = 1'b0; enable = 1'b1; #2;
    vectors++; if (snk_ready !== 1'b0) begin miscompares++; $display("FAIL reset_snk_ready: got %0b want 0", snk_ready); end
    vectors++; if (avm_write !== 1'b0) begin miscompares++; $display("FAIL reset_avm_write: got %0b want 0", avm_write); end
    vectors++; if (avm_writedata !== 16'h0) begin miscompares++; $display("FAIL reset_writedata: got %h want 0000", avm_writedata); end
    vectors++; if (frame_count !== 16'h0) begin miscompares++; $display("FAIL reset_frame_count: got %h want 0000", frame_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
    repeat (2) @(negedge clock);
    reset_n = 1'b1; #1;
    vectors++; if (snk_ready !== 1'b0) begin miscompares++; $display("FAIL release_still_idle: got %0b want 0", snk_ready); end
`ifndef S2M_WRITER_SEQ_HEADER_EN
    step(1'b1, 1'b0, 16'h0, 1'b0, taken);
    vectors++; if (s_rdy !== 1'b1) begin miscompares++; $display("FAIL data_after_first_edge: got %0b want 1", s_rdy); end
`endif
  endtask

  task automatic test_stream;
    logic taken;
    wr_q.delete(); wr_cyc_q.delete();
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 1'b1, 16'(i), 1'b0, taken);
      vectors++; if (taken !== 1'b1) begin miscompares++; $display("FAIL stream_taken[%0d]: got %0b want 1", i, taken); end
    end
    repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0, taken);
    vectors++; if (wr_q.size() != 32) begin miscompares++; $display("FAIL stream_count: got %0d want 32", wr_q.size()); end
    for (int i = 0; i < 32 && i < wr_q.size(); i++) begin
      vectors++; if (wr_q[i] !== 16'(i + 1) || wr_cyc_q[i] != wr_cyc_q[0] + i) begin
        miscompares++; $display("FAIL stream_word[%0d]: got %h@%0d want %h@%0d", i, wr_q[i], wr_cyc_q[i], 16'(i + 1), wr_cyc_q[0] + i);
      end
    end
    vectors++; if (frame_count !== 16'd2) begin miscompares++; $display("FAIL stream_frames: got %0d want 2", frame_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stream_busy: got %0b want 0", busy); end
  endtask

  task automatic test_backpressure;
    logic taken;
    int next = 1, stalls = 0, guard = 0;
    wr_q.delete(); wr_cyc_q.delete();
    while (next <= 16 && guard < 100) begin
      guard++;
      if (next == 4 && stalls < 5) begin
        step(1'b1, 1'b1, 16'h0100 + 16'(next), 1'b1, taken);
        stalls++;
        vectors++; if (s_rdy !== 1'b0) begin miscompares++; $display("FAIL bp_ready[%0d]: got %0b want 0", stalls, s_rdy); end
        vectors++; if (s_write !== 1'b1 || s_wdata !== 16'h0103) begin
          miscompares++; $display("FAIL bp_hold[%0d]: got write=%0b data=%h want write=1 data=0103", stalls, s_write, s_wdata);
        end
      end else begin
        step(1'b1, 1'b1, 16'h0100 + 16'(next), 1'b0, taken);
        if (taken) next++;
      end
    end
    repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0, taken);
    vectors++; if (wr_q.size() != 16) begin miscompares++; $display("FAIL bp_count: got %0d want 16", wr_q.size()); end
    for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
      vectors++; if (wr_q[i] !== 16'h0101 + 16'(i)) begin miscompares++; $display("FAIL bp_word[%0d]: got %h want %h", i, wr_q[i], 16'h0101 + 16'(i)); end
    end
    vectors++; if (frame_count !== 16'd3) begin miscompares++; $display("FAIL bp_frames: got %0d want 3", frame_count); end
  endtask

  task automatic test_pause;
    logic taken;
    int next = 8, guard = 0;
    wr_q.delete(); wr_cyc_q.delete();
    for (int i = 1; i <= 7; i++) step(1'b1, 1'b1, 16'h0200 + 16'(i), 1'b0, taken);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 16'h02FF, 1'b0, taken);
      vectors++; if (s_rdy !== 1'b0) begin miscompares++; $display("FAIL pause_ready[%0d]: got %0b want 0", i, s_rdy); end
    end
    vectors++; if (wr_q.size() != 7 || wr_q[wr_q.size()-1] !== 16'h0207) begin
      miscompares++; $display("FAIL pause_held_written: got %0d words want 7 ending 0207", wr_q.size());
    end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL pause_busy: got %0b want 1", busy); end
    while (next <= 16 && guard < 50) begin
      guard++;
      step(1'b1, 1'b1, 16'h0200 + 16'(next), 1'b0, taken);
      if (taken) next++;
    end
    repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0, taken);
    vectors++; if (wr_q.size() != 16) begin miscompares++; $display("FAIL pause_count: got %0d want 16", wr_q.size()); end
    for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
      vectors++; if (wr_q[i] !== 16'h0201 + 16'(i)) begin miscompares++; $display("FAIL pause_word[%0d]: got %h want %h", i, wr_q[i], 16'h0201 + 16'(i)); end
    end
    vectors++; if (frame_count !== 16'd4) begin miscompares++; $display("FAIL pause_resume_frames: got %0d want 4", frame_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL pause_resume_busy: got %0b want 0", busy); end
  endtask

  task automatic test_reset_mid;
    logic taken;
    wr_q.delete(); wr_cyc_q.delete();
    step(1'b1, 1'b1, 16'h0301, 1'b1, taken);
    vectors++; if (taken !== 1'b1) begin miscompares++; $display("FAIL rst_mid_load: got %0b want 1", taken); end
    step(1'b1, 1'b0, 16'h0, 1'b1, taken);
    vectors++; if (s_write !== 1'b1 || s_wdata !== 16'h0301) begin
      miscompares++; $display("FAIL rst_mid_held: got write=%0b data=%h want write=1 data=0301", s_write, s_wdata);
    end
    #1 reset_n = 1'b0; #1;
    vectors++; if (snk_ready !== 1'b0 || avm_write !== 1'b0 || avm_writedata !== 16'h0) begin
      miscompares++; $display("FAIL rst_mid_bus: got ready=%0b write=%0b data=%h want 0 0 0000", snk_ready, avm_write, avm_writedata);
    end
    vectors++; if (frame_count !== 16'h0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rst_mid_status: got frames=%h busy=%0b want 0000 0", frame_count, busy);
    end
    @(negedge clock);
    reset_n = 1'b1; avm_waitrequest = 1'b0;
    repeat (3) step(1'b1, 1'b0, 16'h0, 1'b0, taken);
    vectors++; if (wr_q.size() != 0) begin miscompares++; $display("FAIL rst_mid_discard: got %0d writes want 0", wr_q.size()); end
  endtask

  task automatic test_wrap;
    logic taken;
    @(negedge clock);
    force dut.frame_cnt_q = 16'hFFFF;
    #1 release dut.frame_cnt_q;
    #1;
    vectors++; if (frame_count !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_preload: got %h want ffff", frame_count); end
    for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 16'h0400 + 16'(i), 1'b0, taken);
    repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0, taken);
    vectors++; if (frame_count !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_before_last: got %h want ffff", frame_count); end
    step(1'b1, 1'b1, 16'h040F, 1'b0, taken);
    repeat (2) step(1'b1, 1'b0, 16'h0, 1'b0, taken);
    vectors++; if (frame_count !== 16'h0000) begin miscompares++; $display("FAIL wrap_rollover: got %h want 0000", frame_count); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wrap_busy: got %0b want 0", busy); end
  endtask

`ifdef S2M_WRITER_SEQ_HEADER_EN
  task automatic test_header;
    logic taken;
    logic [15:0] exp_q[$];
    int next = 0, guard = 0;
    exp_q = '{16'hA000, 16'h0011, 16'h0012, 16'h0013, 16'h0014,
              16'hA001, 16'h0015, 16'h0016, 16'h0017, 16'h0018};
    wr_q.delete(); wr_cyc_q.delete();
    while (next < 8 && guard < 60) begin
      guard++;
      step(1'b1, 1'b1, 16'h0011 + 16'(next), 1'b0, taken);
      if (taken) next++;
    end
    repeat (3) step(1'b0, 1'b0, 16'h0, 1'b0, taken);
    vectors++; if (wr_q.size() != 10) begin miscompares++; $display("FAIL hdr_count: got %0d want 10", wr_q.size()); end
    for (int i = 0; i < 10 && i < wr_q.size(); i++) begin
      vectors++; if (wr_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL hdr_word[%0d]: got %h want %h", i, wr_q[i], exp_q[i]); end
    end
    vectors++; if (frame_count !== 16'd2) begin miscompares++; $display("FAIL hdr_frames: got %0d want 2", frame_count); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef S2M_WRITER_SEQ_HEADER_EN
    test_header();
`else
    test_stream();
    test_backpressure();
    test_pause();
    test_reset_mid();
    test_wrap();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
